// File: rtl/if_fetch.sv
// Instruction-fetch stage: one outstanding request to instruction RAM, valid/allowin hand-off to ID.
// Optional PC alignment check is enabled by defining IF_MISALIGN_CHK_EN.
module if_fetch #(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_valid,
    input  logic            pipe_stall,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_i,

    output logic            inst_req,
    output logic [XLEN-1:0] inst_addr,
    input  logic            inst_gnt,
    input  logic            inst_rvalid,
    input  logic [31:0]     inst_rdata,

    input  logic            id_allowin,
    output logic            if_id_valid,
    output logic [31:0]     if_id_inst,
    output logic [XLEN-1:0] if_id_pc,
    output logic            if_id_misalign
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StDrop,
        StHold
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;

    logic            launch;
    logic            pc_misaligned;

    assign launch = if_valid & ~pipe_stall & ~flush;

`ifdef IF_MISALIGN_CHK_EN
    assign pc_misaligned = |pc_i[1:0];
`else
    assign pc_misaligned = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;

        unique case (state_q)
            StIdle: begin
                if (launch) begin
                    if (pc_misaligned) begin
                        // A misaligned PC never reaches the RAM; ID sees a flagged NOP instead.
                        state_d    = StHold;
                        inst_d     = NOP_INST;
                        pc_d       = pc_i;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = StReq;
                    end
                end
            end

            StReq: begin
                if (flush) begin
                    state_d = inst_gnt ? StDrop : StIdle;
                end else if (inst_gnt) begin
                    state_d = StWait;
                end
            end

            StWait: begin
                if (inst_rvalid) begin
                    if (flush) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StHold;
                        inst_d  = inst_rdata;
                        pc_d    = pc_i;
                    end
                end else if (flush) begin
                    state_d = StDrop;
                end
            end

            StDrop: begin
                // Swallow the one response still owed by the RAM.
                if (inst_rvalid) begin
                    state_d = StIdle;
                end
            end

            StHold: begin
                if (flush) begin
                    state_d    = StIdle;
                    inst_d     = NOP_INST;
                    misalign_d = 1'b0;
                end else if (id_allowin) begin
                    inst_d     = NOP_INST;
                    misalign_d = 1'b0;
                    if (launch) begin
                        if (pc_misaligned) begin
                            state_d    = StHold;
                            pc_d       = pc_i;
                            misalign_d = 1'b1;
                        end else begin
                            state_d = StReq;
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            inst_q     <= NOP_INST;
            pc_q       <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign inst_req       = (state_q == StReq);
    assign inst_addr      = pc_i;
    // Flush masks valid so ID can never complete a handshake in a redirect cycle.
    assign if_id_valid    = (state_q == StHold) & ~flush;
    assign if_id_inst     = inst_q;
    assign if_id_pc       = pc_q;
    assign if_id_misalign = misalign_q;

endmodule
